// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: streaming running max/min of IEEE-754 singles with NaN and empty tracking
module fp_minmax_reduce #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      max_val,
    output logic [31:0]      min_val,
    output logic [IDX_W-1:0] max_idx,
    output logic [IDX_W-1:0] min_idx,
    output logic             nan_seen,
    output logic             empty
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [31:0] qnan = 32'h7FC00000;
    state_t           state;
    logic [IDX_W-1:0] len_r, count;
    logic             have, hs, is_nan, load, upd_max, upd_min, last;
    // Strict "a > b": biased keys order sign-magnitude values; +0/-0 forced equal
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        ka = a[31] ? {1'b0, ~a[30:0]} : {1'b1, a[30:0]};
        kb = b[31] ? {1'b0, ~b[30:0]} : {1'b1, b[30:0]};
        return !(a[30:0] == '0 && b[30:0] == '0) && ka > kb;
    endfunction
    // Handshake decode and per-element compare decisions
    always_comb begin
        hs      = in_valid && in_ready;
        is_nan  = &in_data[30:23] && |in_data[22:0];
        load    = hs && !is_nan && !have;
        upd_max = hs && !is_nan && have && gt(in_data, max_val);
        upd_min = hs && !is_nan && have && gt(min_val, in_data);
        last    = hs && count == len_r - IDX_W'(1);
    end
    // Control FSM with registered outputs and running extrema
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_r    <= '0;
            count    <= '0;
            have     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            max_val  <= '0;
            min_val  <= '0;
            max_idx  <= '0;
            min_idx  <= '0;
            nan_seen <= 1'b0;
            empty    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_r    <= len;
                    count    <= '0;
                    have     <= 1'b0;
                    nan_seen <= 1'b0;
                    max_idx  <= '0;
                    min_idx  <= '0;
                    max_val  <= len == '0 ? qnan : '0;
                    min_val  <= len == '0 ? qnan : '0;
                    empty    <= len == '0;
                    done     <= len == '0;
                    in_ready <= len != '0;
                    busy     <= len != '0;
                    state    <= len == '0 ? DONE : RUN;
                end
                RUN: if (hs) begin
                    count <= count + IDX_W'(1);
                    have  <= have || !is_nan;
                    if (is_nan) nan_seen <= 1'b1;
                    if (load || upd_max) begin
                        max_val <= in_data;
                        max_idx <= count;
                    end
                    if (load || upd_min) begin
                        min_val <= in_data;
                        min_idx <= count;
                    end
                    if (last) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        if (!have && is_nan) begin
                            empty   <= 1'b1;
                            max_val <= qnan;
                            min_val <= qnan;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_minmax_reduce.sv
// tb_fp_minmax_reduce: directed and randomized bursts checked against an arithmetic reference model
module tb_fp_minmax_reduce;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [7:0]  len = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = 0;
    logic        busy, done, nan_seen, empty;
    logic [31:0] max_val, min_val;
    logic [7:0]  max_idx, min_idx;
    int          total = 0;
    int          bad = 0;
    logic [31:0] data [256];
    bit          pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

    fp_minmax_reduce #(.IDX_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
        .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx),
        .nan_seen(nan_seen), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction

    function automatic longint num(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back, 1: fixed gap pattern with stray start, 2: random gaps
    task automatic burst(input int n, input int mode);
        int k = 0;
        int cyc = 0;
        bit hs;
        bit seen = 0;
        bit xnan = 0;
        logic [31:0] emax = 32'h7FC00000;
        logic [31:0] emin = 32'h7FC00000;
        int imax = 0;
        int imin = 0;
        for (int i = 0; i < n; i++) begin
            if (is_nan(data[i])) xnan = 1;
            else if (!seen) begin
                seen = 1; emax = data[i]; emin = data[i]; imax = i; imin = i;
            end else begin
                if (num(data[i]) > num(emax)) begin emax = data[i]; imax = i; end
                if (num(data[i]) < num(emin)) begin emin = data[i]; imin = i; end
            end
        end
        start = 1;
        len = 8'(n);
        step();
        start = 0;
        while (k < n && cyc < 1000) begin
            in_valid = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 8] : 1'($urandom_range(0, 1));
            start = mode == 1 && cyc == 2;
            in_data = data[k];
            chk("in_ready_run", {31'b0, in_ready}, 1);
            chk("busy_run", {31'b0, busy}, 1);
            hs = in_valid && in_ready;
            step();
            if (hs) k++;
            cyc++;
        end
        if (cyc >= 1000) chk("burst_timeout", cyc, 0);
        in_valid = 0;
        start = 0;
        chk("done_pulse", {31'b0, done}, 1);
        chk("busy_done", {31'b0, busy}, 0);
        chk("in_ready_done", {31'b0, in_ready}, 0);
        chk("max_val", max_val, emax);
        chk("min_val", min_val, emin);
        chk("max_idx", {24'b0, max_idx}, imax);
        chk("min_idx", {24'b0, min_idx}, imin);
        chk("nan_seen", {31'b0, nan_seen}, {31'b0, xnan});
        chk("empty", {31'b0, empty}, {31'b0, !seen});
        step();
        chk("done_drop", {31'b0, done}, 0);
        chk("max_hold", max_val, emax);
        chk("min_hold", min_val, emin);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h7FC00000 | 32'($urandom_range(0, 255));
            1: return $urandom_range(0, 1) ? 32'h80000000 : 32'h00000000;
            2: return $urandom_range(0, 1) ? 32'hFF800000 : 32'h7F800000;
            3: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(1, 1000))};
            4: return {1'($urandom_range(0, 1)), 8'h80, 23'($urandom_range(0, 3))};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_empty", {31'b0, empty}, 0);
        chk("rst_max", max_val, 0);
        step();
        rst = 0;
        step();
        in_valid = 1;
        in_data = 32'h12345678;
        step();
        in_valid = 0;
        chk("idle_ignore_valid", {31'b0, busy}, 0);
        data[0] = 32'h3F800000; data[1] = 32'hC0000000; data[2] = 32'h40400000; data[3] = 32'h00000000;
        burst(4, 0);
        data[0] = 32'h7FC00001; data[1] = 32'hBF800000; data[2] = 32'h7F800000;
        burst(3, 0);
        data[0] = 32'h80000000; data[1] = 32'h00000000;
        burst(2, 0);
        data[0] = 32'h7FC00000; data[1] = 32'hFFC00000;
        burst(2, 0);
        burst(0, 0);
        data[0] = 32'h40A00000; data[1] = 32'hC1200000; data[2] = 32'h00000001;
        data[3] = 32'h40A00000; data[4] = 32'hC1200000;
        burst(5, 1);
        for (int t = 0; t < 12; t++) begin
            int n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) data[i] = rnd_val();
            burst(n, 2);
        end
        start = 1;
        len = 4;
        step();
        start = 0;
        in_valid = 1;
        in_data = 32'h3F800000;
        step();
        step();
        #3;
        rst = 1;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_in_ready", {31'b0, in_ready}, 0);
        chk("arst_done", {31'b0, done}, 0);
        chk("arst_max", max_val, 0);
        chk("arst_min", min_val, 0);
        chk("arst_idx", {16'b0, max_idx, min_idx}, 0);
        chk("arst_flags", {30'b0, nan_seen, empty}, 0);
        in_valid = 0;
        step();
        rst = 0;
        data[0] = 32'h41200000;
        burst(1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_minmax_reduce.md
Name: fp_minmax_reduce

Overview:
- Streaming consumer of IEEE-754 single-precision values. Sits downstream of the FPU compare logic in the vector/reduction path.
- Accepts a burst of LEN operands over a valid/ready handshake and tracks running max and min, with the element index of each.
- Reports results, a NaN-seen flag and an empty flag at end of burst.
- Performs its own ordering compare internally, one compare pair per accepted element.

Parameters:
- IDX_W, 8, width of length/index fields; max burst length is 2^IDX_W - 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a burst; sampled only in IDLE.
- len  input  IDX_W  number of elements in the burst; sampled with start.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  single-precision operand.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; results valid from this cycle.
- max_val  output  32  largest non-NaN element.
- min_val  output  32  smallest non-NaN element.
- max_idx  output  IDX_W  burst index (0-based) of max_val.
- min_idx  output  IDX_W  burst index of min_val.
- nan_seen  output  1  at least one NaN was accepted in the burst.
- empty  output  1  no non-NaN element was accepted.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: in_ready, busy, done, max_val, min_val, max_idx, min_idx, nan_seen, empty.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and len>0 -> RUN. Clear count, nan_seen, empty and the have-value flag.
  - start=1 and len=0 -> DONE with empty=1, nan_seen=0.
- RUN:
  - in_ready=1 and busy=1.
  - A handshake occurs when in_valid and in_ready are both high; count then increments by one.
  - start is ignored in RUN.
  - The handshake on element count=len-1 moves the block to DONE on the next edge.
- DONE (one cycle):
  - done=1, in_ready=0, busy=0. Next state is IDLE.
  - empty=1 if no non-NaN element was accepted. In that case max_val = min_val = 32'h7FC00000 and both indices are 0.
  - Result outputs hold until the next start is accepted. They are cleared at that start.
- Latency: done is asserted the cycle after the final handshake.
- NaN: exp=8'hFF and mantissa!=0. Sets nan_seen and is excluded from comparison. It still consumes an index.
- First non-NaN element loads max and min and sets both indices to its position.
- Ordering rules:
  - Sign-magnitude compare: a positive value is greater than any negative value.
  - Among positives, a larger {exp,mantissa} is greater. Among negatives, a smaller {exp,mantissa} is greater.
  - -0 and +0 compare equal. ±Inf are ordinary extremes. Denormals are ordered by raw magnitude.
- Updates:
  - Update max only if the new value is strictly greater; update min only if strictly less.
  - Ties keep the earliest index and the originally stored bit pattern (e.g. -0 first, then +0 -> stored value stays -0).
- The same element may update both max and min (first element only).
- in_valid while not in RUN is ignored; no data is consumed.
- in_valid dropping mid-burst stalls with no state change. There is no timeout.

Test Plan:
- start, len=4, stream 3F800000(1.0), C0000000(-2.0), 40400000(3.0), 00000000 with back-to-back valid -> done 1 cycle after 4th handshake; max_val=40400000 max_idx=2, min_val=C0000000 min_idx=1, nan_seen=0, empty=0.
- len=3: 7FC00001(NaN), BF800000(-1.0), 7F800000(+Inf) -> nan_seen=1, max_val=7F800000 idx=2, min_val=BF800000 idx=1.
- len=2: 80000000(-0), 00000000(+0) -> equal; max_val=min_val=80000000, both idx=0.
- len=2 all NaN (7FC00000, FFC00000) -> empty=1, nan_seen=1, max_val=min_val=7FC00000, idx=0. Separately, start with len=0 -> done on the cycle after start, empty=1, nan_seen=0.
- len=5 with in_valid gapped (1,0,0,1,1,0,1,1) plus start pulsed mid-burst -> only 5 elements accepted; start ignored; done 1 cycle after 5th handshake; results correct for the values sent.
- Assert rst asynchronously mid-burst after 2 elements -> all outputs 0 immediately. A following start with len=1 and a 41200000 input gives max=min=41200000, idx 0.
